// File: rtl/pe_frame_pkg.sv
// -----------------------------------------------------------------------------
// pe_frame_pkg
// Shared definitions for the PE result-stream framer:
//   - frame_state_e : framer FSM encoding (FILL, HDR, PAY, TRL)
//   - header field bit offsets, default header magic, trailer tag
//   - cnt_width()   : width of a counter that must hold 0..max_val inclusive
// -----------------------------------------------------------------------------
package pe_frame_pkg;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2,
    ST_TRL  = 2'd3
  } frame_state_e;

  // Header word layout: {magic[63:48], seq[47:32], 16'h0, len[15:0]}
  localparam int HDR_MAGIC_LSB = 48;
  localparam int HDR_SEQ_LSB   = 32;
  localparam int HDR_LEN_LSB   = 0;

  localparam logic [15:0] DEFAULT_MAGIC = 16'hFC01;
  localparam logic [31:0] TRAILER_TAG   = 32'hC5C5C5C5;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/frame_buf.sv
// -----------------------------------------------------------------------------
// frame_buf
// Simple dual-port frame RAM, DEPTH words of DATA_W bits.
// Ports:
//   CLK      : clock
//   wr_en    : write strobe (one accepted PE word)
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address, sampled every cycle
//   rd_data  : registered read data (1-cycle latency)
// -----------------------------------------------------------------------------
module frame_buf #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic              CLK,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pe_q_framer.sv
// -----------------------------------------------------------------------------
// pe_q_framer
// Drains the PE first-word-fall-through result stream into a single frame
// buffer and emits length-prefixed frames on a valid/ready TX stream.
// A frame closes when full, after IDLE_TIMEOUT idle cycles, or on FLUSH.
//
// Ports:
//   CLK        : clock
//   SYS_RST_N  : synchronous reset, active-low
//   Q          : PE result word
//   Q_VALID    : Q carries a word (PE pops whenever Q_BP=0)
//   Q_BP       : backpressure to PE, 1 = do not pop
//   FLUSH      : single-cycle request to close the current partial frame
//   TX_DATA    : frame word (header, payload, optional trailer)
//   TX_VALID   : TX_DATA valid
//   TX_LAST    : final word of frame
//   TX_READY   : downstream accepts when TX_VALID & TX_READY
//   FRAME_SEQ  : sequence number of the next frame to be sent
//
// Optional build macro PE_Q_FRAMER_CHECKSUM_EN: appends a trailer word
// {32'hC5C5C5C5, xor[63:32]^xor[31:0]} carrying TX_LAST, where xor is the
// XOR of all payload words of the frame. Header length stays payload-only.
// -----------------------------------------------------------------------------
module pe_q_framer
  import pe_frame_pkg::*;
#(
  parameter int          FRAME_WORDS  = 256,
  parameter int          IDLE_TIMEOUT = 1024,
  parameter logic [15:0] MAGIC        = DEFAULT_MAGIC
) (
  input  logic        CLK,
  input  logic        SYS_RST_N,
  input  logic [63:0] Q,
  input  logic        Q_VALID,
  output logic        Q_BP,
  input  logic        FLUSH,
  output logic [63:0] TX_DATA,
  output logic        TX_VALID,
  output logic        TX_LAST,
  input  logic        TX_READY,
  output logic [15:0] FRAME_SEQ
);

  localparam int             DATA_W  = 64;
  localparam int             AW      = $clog2(FRAME_WORDS);
  localparam int             CW      = cnt_width(FRAME_WORDS);
  localparam int             TW      = cnt_width(IDLE_TIMEOUT);
  localparam bit             TO_EN   = (IDLE_TIMEOUT > 0);
  localparam logic [TW-1:0]  TO_LAST = TO_EN ? TW'(IDLE_TIMEOUT - 1) : '0;
  localparam logic [CW-1:0]  FULL    = CW'(FRAME_WORDS);

  frame_state_e      state, state_d;
  logic [CW-1:0]     count, count_d;
  logic [CW-1:0]     nxt_idx, nxt_d;
  logic [TW-1:0]     timer, timer_d;
  logic [15:0]       seq, seq_d;
  logic [DATA_W-1:0] rd_word_p1;
  logic [DATA_W-1:0] tx_data_p2, tx_data_d;
  logic              tx_vld_p2, tx_vld_d;
  logic              tx_last_p2, tx_last_d;
  logic              is_full, accept, tx_fire, timeout_hit, close, finish;
`ifdef PE_Q_FRAMER_CHECKSUM_EN
  logic [DATA_W-1:0] csum, csum_d;
`endif

  function automatic logic [63:0] make_header(input logic [15:0] s,
                                              input logic [CW-1:0] len);
    return (64'(MAGIC) << HDR_MAGIC_LSB) |
           (64'(s)     << HDR_SEQ_LSB)   |
           (64'(len)   << HDR_LEN_LSB);
  endfunction

  assign is_full     = (count == FULL);
  assign Q_BP        = (state != ST_FILL) | is_full;
  // The PE has already popped whenever it saw Q_BP low, so this is never optional.
  assign accept      = Q_VALID & ~Q_BP;
  assign tx_fire     = tx_vld_p2 & TX_READY;
  // Timeout fires on the idle cycle that would bring timer up to IDLE_TIMEOUT.
  assign timeout_hit = TO_EN & ~accept & (timer == TO_LAST);
  assign close       = is_full | ((count != '0) & (FLUSH | timeout_hit));

  // Stage p0 -> p1: frame RAM. The read address is the next-cycle value of
  // nxt_idx, so rd_word_p1 always holds buf[nxt_idx] and a payload word can be
  // loaded on every handshake without a bubble.
  frame_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (FRAME_WORDS),
    .AW     (AW)
  ) u_buf (
    .CLK     (CLK),
    .wr_en   (accept),
    .wr_addr (count[AW-1:0]),
    .wr_data (Q),
    .rd_addr (nxt_d[AW-1:0]),
    .rd_data (rd_word_p1)
  );

  always_comb begin
    state_d   = state;
    count_d   = count;
    timer_d   = timer;
    seq_d     = seq;
    nxt_d     = nxt_idx;
    tx_data_d = tx_data_p2;
    tx_vld_d  = tx_vld_p2;
    tx_last_d = tx_last_p2;
    finish    = 1'b0;
`ifdef PE_Q_FRAMER_CHECKSUM_EN
    csum_d    = csum;
`endif
    case (state)
      ST_FILL: begin
        nxt_d = '0;
        if (accept) begin
          count_d = count + CW'(1);
          timer_d = '0;
`ifdef PE_Q_FRAMER_CHECKSUM_EN
          csum_d  = (count == '0) ? Q : (csum ^ Q);
`endif
        end else if (TO_EN && (count != '0)) begin
          timer_d = timer + TW'(1);
        end else begin
          timer_d = '0;
        end
        if (close) begin
          state_d   = ST_HDR;
          timer_d   = '0;
          tx_vld_d  = 1'b1;
          tx_last_d = 1'b0;
          tx_data_d = make_header(seq, count_d);
        end
      end
      ST_HDR: begin
        if (tx_fire) begin
          state_d   = ST_PAY;
          tx_data_d = rd_word_p1;
          nxt_d     = CW'(1);
`ifdef PE_Q_FRAMER_CHECKSUM_EN
          tx_last_d = 1'b0;
`else
          tx_last_d = (count == CW'(1));
`endif
        end
      end
      ST_PAY: begin
        if (tx_fire) begin
`ifdef PE_Q_FRAMER_CHECKSUM_EN
          if (nxt_idx == count) begin
            state_d   = ST_TRL;
            tx_data_d = {TRAILER_TAG, csum[63:32] ^ csum[31:0]};
            tx_last_d = 1'b1;
          end else begin
            tx_data_d = rd_word_p1;
            tx_last_d = 1'b0;
            nxt_d     = nxt_idx + CW'(1);
          end
`else
          if (tx_last_p2) begin
            finish = 1'b1;
          end else begin
            tx_data_d = rd_word_p1;
            tx_last_d = (nxt_idx == count - CW'(1));
            nxt_d     = nxt_idx + CW'(1);
          end
`endif
        end
      end
      ST_TRL: begin
        if (tx_fire) finish = 1'b1;
      end
      default: state_d = ST_FILL;
    endcase
    if (finish) begin
      state_d   = ST_FILL;
      tx_vld_d  = 1'b0;
      tx_last_d = 1'b0;
      seq_d     = seq + 16'd1;
      count_d   = '0;
      nxt_d     = '0;
    end
  end

  // Stage p1 -> p2: FSM state and TX output register.
  always_ff @(posedge CLK) begin
    if (!SYS_RST_N) begin
      state      <= ST_FILL;
      count      <= '0;
      timer      <= '0;
      seq        <= '0;
      nxt_idx    <= '0;
      tx_vld_p2  <= 1'b0;
      tx_last_p2 <= 1'b0;
      tx_data_p2 <= '0;
    end else begin
      state      <= state_d;
      count      <= count_d;
      timer      <= timer_d;
      seq        <= seq_d;
      nxt_idx    <= nxt_d;
      tx_vld_p2  <= tx_vld_d;
      tx_last_p2 <= tx_last_d;
      tx_data_p2 <= tx_data_d;
    end
  end

`ifdef PE_Q_FRAMER_CHECKSUM_EN
  always_ff @(posedge CLK) begin
    csum <= csum_d;
  end
`endif

  assign TX_DATA   = tx_data_p2;
  assign TX_VALID  = tx_vld_p2;
  assign TX_LAST   = tx_last_p2;
  assign FRAME_SEQ = seq;

endmodule

// File: doc/pe_q_framer.md
Name: pe_q_framer

Overview:
- Sits directly downstream of the PE wrapper output port.
- Drains the PE's first-word-fall-through result stream (Q/Q_VALID/Q_BP) into a frame buffer.
- Emits length-prefixed frames on a valid/ready TX stream toward the host DMA/network transmit path.
- A frame closes on reaching FRAME_WORDS words, on an idle timeout, or on an explicit FLUSH.

Parameters:
- FRAME_WORDS, 256, max payload words per frame (power of 2, 2..512)
- IDLE_TIMEOUT, 1024, cycles without an accepted word (count>0) before a partial frame is flushed; 0 disables the timeout
- MAGIC, 16'hFC01, header magic in bits [63:48]

Ports:
- CLK  in  1  single clock
- SYS_RST_N  in  1  synchronous reset, active-low
- Q  in  64  PE result word
- Q_VALID  in  1  Q carries a word this cycle; the PE pops its FIFO whenever Q_BP=0
- Q_BP  out  1  backpressure to PE; 1 = do not pop
- FLUSH  in  1  single-cycle request to close the current partial frame
- TX_DATA  out  64  frame word
- TX_VALID  out  1  TX_DATA valid
- TX_LAST  out  1  final word of frame
- TX_READY  in  1  downstream accepts the word when TX_VALID&TX_READY
- FRAME_SEQ  out  16  sequence number of the next frame to be sent

Behaviour:
- Reset (SYS_RST_N=0 at a CLK edge):
  - state=FILL, count=0, seq=0, timer=0.
  - TX_VALID=0, TX_LAST=0, TX_DATA=0, FRAME_SEQ=0.
  - Q_BP=0 from the first cycle after reset.
- Reset mid-frame: buffered words and the partially sent frame are discarded; no TX_LAST is emitted.
- Q_BP is combinational from registers only: Q_BP = (state!=FILL) | (count==FRAME_WORDS).
  - Any cycle with Q_BP=0 and Q_VALID=1 is a mandatory accept, because the PE has already popped the word.
  - The word is written to buf[count] and count increments.
- FILL state:
  - Go to HDR next cycle if count==FRAME_WORDS.
  - Else go to HDR if count>0 and (FLUSH=1 or timer reaches IDLE_TIMEOUT).
  - FLUSH with count==0 is ignored (no empty frames).
  - A word accepted in the same cycle as FLUSH or timeout is included in the frame.
- Timer: increments in FILL when count>0 and no word is accepted; clears on accept and on leaving FILL.
- HDR state:
  - Drive TX_DATA = {MAGIC, seq[15:0], 16'h0, len[15:0]}, with len=count latched on entry.
  - TX_VALID=1, TX_LAST=0.
  - On TX_READY, go to PAY.
- PAY state:
  - Stream buf[0..len-1]; TX_LAST=1 on word len-1 (or on the trailer when the optional feature is enabled).
  - The read side prefetches so that TX_VALID stays high back-to-back with no bubble while TX_READY=1.
  - On the final handshake: seq<=seq+1 (wraps 16'hFFFF->0), count<=0, go to FILL.
- Valid/ready rules:
  - While TX_VALID=1 and TX_READY=0, TX_DATA and TX_LAST are held stable.
  - TX_VALID never drops without a handshake.
- Latency:
  - Header TX_VALID is asserted 1 cycle after the closing condition.
  - First payload word follows the header handshake by 1 cycle at most.
- No input is accepted during HDR/PAY (Q_BP=1); the single buffer is the intended throughput tradeoff.

Optional Feature:
- Macro: PE_Q_FRAMER_CHECKSUM_EN.
- Defined:
  - An XOR accumulator over accepted payload words, cleared on frame start.
  - After the last payload word, one trailer word {32'hC5C5C5C5, xor[63:32]^xor[31:0]} is emitted with TX_LAST=1.
  - The header len is unchanged (payload only).
- Undefined: no trailer; TX_LAST is on the last payload word; no accumulator logic.

Decomposition:
- Package pe_frame_pkg:
  - State encoding (FILL, HDR, PAY, TRL).
  - Header field bit offsets, default MAGIC, trailer tag constant.
  - Width function for count/timer.
- Sub-module frame_buf: simple dual-port RAM (64 x FRAME_WORDS, 1-cycle synchronous read, write port on accept, read port on TX side).

Test Plan:
- 256 consecutive Q_VALID words 0..255, TX_READY=1 -> Q_BP rises when count==256; header {FC01,0000,0000,0100}; payload 0..255; TX_LAST on 255; seq becomes 1; Q_BP low again.
- 5 words, then idle with IDLE_TIMEOUT=16 -> header len=5 exactly 17 cycles after the last accept; 5 payload words follow.
- 3 words, FLUSH pulsed in the same cycle as the 4th word -> frame len=4 includes the 4th word; FLUSH with count==0 -> no TX activity.
- TX_READY toggling randomly 50% -> TX_DATA/TX_LAST stable while stalled; output sequence is bit-exact with the input; no words lost during Q_BP transitions.
- Force seq=16'hFFFF via 65535 one-word frames (or a backdoor) -> next header seq=FFFF, the following one 0000.
- SYS_RST_N low in the middle of PAY -> TX_VALID=0 next cycle, Q_BP=0, FRAME_SEQ=0; next frame header seq=0. With PE_Q_FRAMER_CHECKSUM_EN and payload {1,2,3}: trailer {C5C5C5C5, 00000000} with TX_LAST.
